// File: rtl/emu_osc_gen.sv
// Emulated-time oscillator: asks for the time left to its next edge each
// emu_clk and toggles once the granted timestep uses that time up.
module emu_osc_gen #(
  parameter int DT_WIDTH  = 27,
  parameter int T_LO_DEF  = 100,
  parameter int T_HI_DEF  = 100,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic [DT_WIDTH-1:0]  t_lo,
  input  logic [DT_WIDTH-1:0]  t_hi,
  input  logic [DT_WIDTH-1:0]  emu_dt,
  output logic [DT_WIDTH-1:0]  dt_req,
  output logic                 clk_val,
  output logic                 cke_rise,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 dt_err
);

  typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

  localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);
  // A zero default would request dt=0 and stall the emulator.
  localparam logic [DT_WIDTH-1:0] LO_RST =
    (T_LO_DEF < 1) ? ONE : DT_WIDTH'(T_LO_DEF);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [DT_WIDTH-1:0]    rem_q, rem_d;
  logic [DT_WIDTH-1:0]    lo_c, hi_c;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   hit;

  // Durations are sampled at the edge that starts the next half-period.
  always_comb begin
    lo_c = (t_lo == '0) ? ONE : t_lo;
    hi_c = (t_hi == '0) ? ONE : t_hi;
  end

  // Next-state: consume the grant or toggle when it covers the remainder.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hit     = (emu_dt >= rem_q);
    if (hit) begin
      cnt_d = cnt_q + CNT_ONE;
      if (emu_dt > rem_q) err_d = 1'b1;
      if (state_q == LO) begin
        state_d = HI;
        rem_d   = hi_c;
      end else begin
        state_d = LO;
        rem_d   = lo_c;
      end
    end else begin
      rem_d = rem_q - emu_dt;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q <= LO;
      rem_q   <= LO_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from state, except the rising-edge enable.
  always_comb begin
    dt_req   = rem_q;
    clk_val  = (state_q == HI);
    edge_cnt = cnt_q;
    dt_err   = err_q;
    cke_rise = (state_q == LO) && hit && !emu_rst;
  end

endmodule
